quad_step_decoder: RTL and testbench

- Quadrature front end that drives the 4-bit up/down counter's enable and direction inputs.
- Synchronises and glitch-filters two asynchronous quadrature inputs (qa, qb).
- Decodes Gray-code transitions into single-cycle step pulses with a direction bit.
- Flags illegal double-bit transitions and counts them in a saturating error counter.

---
 rtl/quad_step_decoder.sv | 156 +++++++++++++++
 tb/tb_quad_step_decoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronises and glitch-filters {qa,qb}, then
// turns each accepted Gray-code transition into a one-cycle step pulse with
// a direction bit. Both-bit jumps raise err and bump a saturating counter.
//
// Output qualification: step_dir is only meaningful while step_en is high.
// It keeps its last value between pulses. step_en and err are one-cycle
// strobes with no back-pressure; the downstream counter must take them on
// the cycle they are high.
module quad_step_decoder #(
  parameter int FILT_LEN = 4,
  parameter bit REV      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       qa,
  input  logic       qb,
  input  logic       en,
  input  logic       clr_err,
  output logic       step_en,
  output logic       step_dir,
  output logic       err,
  output logic [3:0] err_cnt,
  output logic       tracking
);

  localparam logic [3:0] FILT_LEN_C = 4'(FILT_LEN);

  typedef enum logic {ST_INIT, ST_TRACK} state_t;

  state_t      state_q, state_d;
  logic [1:0]  s1, s2;
  logic [1:0]  filt, cand, cand_d;
  logic [3:0]  hold_cnt, hold_d;
  logic [1:0]  warm;
  logic        accept;
  logic [1:0]  gray_diff;
  logic        step_d, dir_d, err_d;
  logic [3:0]  cnt_d;

  // Gray position of a quadrature pair: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gray_idx(input logic [1:0] v);
    return {v[1], v[1] ^ v[0]};
  endfunction

  // Two-flop synchroniser plus a short warm-up count so INIT never
  // trusts the pre-reset contents of the synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 2'b00;
      s2   <= 2'b00;
      warm <= 2'd0;
    end else begin
      s1 <= {qa, qb};
      s2 <= s1;
      if (warm != 2'd2) warm <= warm + 2'd1;
    end
  end

  // Hold filter: a new value must persist FILT_LEN edges before acceptance.
  always_comb begin
    accept = 1'b0;
    hold_d = hold_cnt;
    cand_d = cand;
    if (s2 == filt) begin
      hold_d = 4'd0;
    end else if (hold_cnt != 4'd0 && s2 == cand) begin
      if (hold_cnt + 4'd1 == FILT_LEN_C) begin
        accept = 1'b1;
        hold_d = 4'd0;
      end else begin
        hold_d = hold_cnt + 4'd1;
      end
    end else begin
      cand_d = s2;
      if (FILT_LEN_C == 4'd1) begin
        accept = 1'b1;
        hold_d = 4'd0;
      end else begin
        hold_d = 4'd1;
      end
    end
  end

  // Filter state: filt follows every accepted value, in every FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt     <= 2'b00;
      cand     <= 2'b00;
      hold_cnt <= 4'd0;
    end else begin
      cand     <= cand_d;
      hold_cnt <= hold_d;
      if (accept) filt <= s2;
    end
  end

  assign gray_diff = gray_idx(s2) - gray_idx(filt);

  // Next state and registered-output values; INIT learns the level silently.
  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    dir_d   = step_dir;
    cnt_d   = err_cnt;
    case (state_q)
      ST_INIT: begin
        if (accept || (warm == 2'd2 && s2 == filt && hold_cnt == 4'd0)) begin
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (accept && en) begin
          case (gray_diff)
            2'd1: begin
              step_d = 1'b1;
              dir_d  = ~REV;
            end
            2'd3: begin
              step_d = 1'b1;
              dir_d  = REV;
            end
            2'd2:    err_d = 1'b1;
            default: err_d = 1'b0;
          endcase
        end
      end
      default: state_d = ST_INIT;
    endcase
    if (clr_err) begin
      cnt_d = 4'd0;
    end else if (err_d && err_cnt != 4'd15) begin
      cnt_d = err_cnt + 4'd1;
    end
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_INIT;
      step_en  <= 1'b0;
      step_dir <= 1'b1;
      err      <= 1'b0;
      err_cnt  <= 4'd0;
    end else begin
      state_q  <= state_d;
      step_en  <= step_d;
      step_dir <= dir_d;
      err      <= err_d;
      err_cnt  <= cnt_d;
    end
  end

  assign tracking = (state_q == ST_TRACK);

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: two instances (REV=0 and REV=1) share inputs.
// Each driven filtered change pushes the expected pulse into exp_q; a
// negedge monitor pops and checks every pulse the DUTs produce.
module tb_quad_step_decoder;

  localparam int FL = 2;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic qa = 1'b0, qb = 1'b0, en = 1'b1, clr_err = 1'b0;
  logic       step_en, step_dir, err, tracking;
  logic [3:0] err_cnt;
  logic       step_en_r, step_dir_r, err_r, tracking_r;
  logic [3:0] err_cnt_r;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  quad_step_decoder #(.FILT_LEN(FL), .REV(1'b0)) dut (
    .clk(clk), .rst(rst), .qa(qa), .qb(qb), .en(en), .clr_err(clr_err),
    .step_en(step_en), .step_dir(step_dir), .err(err), .err_cnt(err_cnt),
    .tracking(tracking)
  );

  quad_step_decoder #(.FILT_LEN(FL), .REV(1'b1)) dut_r (
    .clk(clk), .rst(rst), .qa(qa), .qb(qb), .en(en), .clr_err(clr_err),
    .step_en(step_en_r), .step_dir(step_dir_r), .err(err_r), .err_cnt(err_cnt_r),
    .tracking(tracking_r)
  );

  // Scoreboard: {step, err, dir, dir_rev, cnt[3:0], cycle[15:0]}
  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;
  logic [1:0]  m_filt = 2'b00;
  logic        m_dir = 1'b1, m_dir_r = 1'b1;
  logic [3:0]  m_cnt = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_next(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Model one filtered change of the input pair, issued at the current cycle.
  task automatic expect_change(input logic [1:0] v);
    logic s, e;
    s = 1'b0;
    e = 1'b0;
    if (v == m_filt) return;
    if (en) begin
      if (fwd_next(m_filt) == v) begin
        s = 1'b1; m_dir = 1'b1; m_dir_r = 1'b0;
      end else if (fwd_next(v) == m_filt) begin
        s = 1'b1; m_dir = 1'b0; m_dir_r = 1'b1;
      end else begin
        e = 1'b1;
        if (clr_err) m_cnt = 4'd0;
        else if (m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
      end
      exp_q.push_back({s, e, m_dir, m_dir_r, m_cnt, 16'(cyc + FL + 2)});
    end
    m_filt = v;
  endtask

  // Driver: change {qa,qb} just after a falling edge, then hold.
  task automatic drive(input logic [1:0] v, input int hold);
    @(negedge clk);
    {qa, qb} = v;
    expect_change(v);
    repeat (hold) @(negedge clk);
  endtask

  // Monitor: every pulse from either instance must match the queue head.
  always @(negedge clk) begin
    if (step_en | err | step_en_r | err_r) begin
      chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("step_en",    32'(step_en),    32'(mon_e[23]));
        chk("err",        32'(err),        32'(mon_e[22]));
        chk("step_dir",   32'(step_dir),   32'(mon_e[21]));
        chk("err_cnt",    32'(err_cnt),    32'(mon_e[19:16]));
        chk("step_en_r",  32'(step_en_r),  32'(mon_e[23]));
        chk("err_r",      32'(err_r),      32'(mon_e[22]));
        chk("step_dir_r", 32'(step_dir_r), 32'(mon_e[20]));
        chk("err_cnt_r",  32'(err_cnt_r),  32'(mon_e[19:16]));
        chk("latency",    32'(cyc[15:0]),  32'(mon_e[15:0]));
      end
    end
  end

  initial begin
    // Reset with inputs at 00
    repeat (3) @(negedge clk);
    chk("rst_step_en",  32'(step_en),  32'd0);
    chk("rst_step_dir", 32'(step_dir), 32'd1);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_err_cnt",  32'(err_cnt),  32'd0);
    chk("rst_tracking", 32'(tracking), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("init_tracking",   32'(tracking),   32'd1);
    chk("init_tracking_r", 32'(tracking_r), 32'd1);

    // Forward sequence
    drive(2'b01, 6); drive(2'b11, 6); drive(2'b10, 6); drive(2'b00, 6);
    chk("fwd_dir_hold", 32'(step_dir), 32'd1);
    chk("fwd_err_cnt",  32'(err_cnt),  32'd0);

    // Reverse sequence
    drive(2'b10, 6); drive(2'b11, 6); drive(2'b01, 6); drive(2'b00, 6);
    chk("rev_dir_hold",   32'(step_dir),   32'd0);
    chk("rev_dir_hold_r", 32'(step_dir_r), 32'd1);

    // One-cycle qa glitch must be rejected
    @(negedge clk); qa = 1'b1;
    @(negedge clk); qa = 1'b0;
    repeat (6) @(negedge clk);

    // Three-cycle qb pulse: one up step, then the return down step
    @(negedge clk); qb = 1'b1; expect_change(2'b01);
    repeat (3) @(negedge clk);
    qb = 1'b0; expect_change(2'b00);
    repeat (6) @(negedge clk);
    chk("glitch_dir", 32'(step_dir), 32'd0);

    // Illegal transitions and saturation
    drive(2'b11, 6);
    chk("err_cnt_one", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 16; i++) drive((i % 2 == 0) ? 2'b00 : 2'b11, 6);
    chk("err_cnt_sat",   32'(err_cnt),   32'd15);
    chk("err_cnt_sat_r", 32'(err_cnt_r), 32'd15);

    // Single-cycle clear
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0; m_cnt = 4'd0;
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);

    // Clear held across an illegal transition: err pulses, count stays 0
    @(negedge clk); clr_err = 1'b1;
    drive(2'b00, 6);
    clr_err = 1'b0;
    @(negedge clk);
    chk("clr_coincident_cnt", 32'(err_cnt), 32'd0);

    // Decode disabled while the input walks forward
    @(negedge clk); en = 1'b0;
    drive(2'b01, 6); drive(2'b11, 6); drive(2'b10, 6);
    @(negedge clk); en = 1'b1;
    chk("en_off_err_cnt", 32'(err_cnt), 32'(m_cnt));
    chk("en_off_dir",     32'(step_dir), 32'd0);
    drive(2'b00, 6);
    drive(2'b01, 6);

    // Reset while a new value (11) is still being held
    @(negedge clk); {qa, qb} = 2'b11;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_step_en",  32'(step_en),  32'd0);
    chk("mid_rst_step_dir", 32'(step_dir), 32'd1);
    chk("mid_rst_err",      32'(err),      32'd0);
    chk("mid_rst_tracking", 32'(tracking), 32'd0);
    m_dir = 1'b1; m_dir_r = 1'b1; m_cnt = 4'd0; m_filt = 2'b11;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("relearn_tracking", 32'(tracking), 32'd1);
    chk("relearn_err_cnt",  32'(err_cnt),  32'd0);
    chk("relearn_step_dir", 32'(step_dir), 32'd1);

    // Nothing expected may be left unmatched
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
